seq_arbiter: RTL and testbench

SEQ_ARBITER -- requirements
Module: seq_arbiter

---
 rtl/seq_arbiter.sv | 114 +++++++++++
 tb/tb_seq_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_arbiter.sv
// Round-robin arbiter granting n requesters access to a shared program sequencer,
// issuing the winner's start address and watching seq_stop for start/completion.
module seq_arbiter #(
  parameter int unsigned n   = 4,
  parameter int unsigned aw  = 5,
  parameter int unsigned tmo = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [n-1:0]    req,
  input  logic [n*aw-1:0] addr,
  output logic [n-1:0]    grant,
  output logic [n-1:0]    done,
  output logic            err,
  output logic [aw-1:0]   seq_addr,
  output logic            seq_jump,
  input  logic            seq_stop
);

  localparam int unsigned iw = $clog2(n);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StRun, StFin} state_e;

  state_e        state_q;
  logic [iw-1:0] last_q;
  logic [iw-1:0] owner_q;
  logic [7:0]    cnt_q;

  logic          win_valid;
  logic [iw-1:0] win_idx;
  logic [iw-1:0] cand;
  logic [aw-1:0] win_addr;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= int'(n); i++) begin
      cand = iw'((int'(last_q) + i) % int'(n));
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_addr = '0;
    for (int k = 0; k < int'(n); k++) begin
      if (iw'(k) == win_idx) win_addr = addr[k*aw +: aw];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant    <= '0;
      done     <= '0;
      err      <= 1'b0;
      seq_jump <= 1'b0;
      seq_addr <= '0;
      last_q   <= iw'(n - 1);
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      seq_jump <= 1'b0;
      done     <= '0;
      err      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (seq_stop && win_valid) begin
            state_q  <= StIssue;
            grant    <= n'(1) << win_idx;
            owner_q  <= win_idx;
            seq_addr <= win_addr;
            seq_jump <= 1'b1;
          end
        end
        StIssue: begin
          state_q <= StWait;
          cnt_q   <= 8'd1;
        end
        StWait: begin
          if (!seq_stop) begin
            state_q <= StRun;
          end else if (cnt_q == 8'(tmo)) begin
            // Sequencer never started: give up and let the next requester in.
            err     <= 1'b1;
            grant   <= '0;
            last_q  <= owner_q;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StRun: begin
          if (seq_stop) begin
            state_q <= StFin;
            done    <= grant;
          end
        end
        StFin: begin
          grant   <= '0;
          last_q  <= owner_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arbiter.sv
// Directed bench for seq_arbiter: stimulus pushes expected jump/done/err events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_seq_arbiter;

  localparam int N = 4;
  localparam int AW = 5;
  localparam int EvJump = 0;
  localparam int EvDone = 1;
  localparam int EvErr  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            err;
  logic [AW-1:0]   seq_addr;
  logic            seq_jump;
  logic            seq_stop = 1'b1;

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic [31:0] adr;
    int          delay;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  jump_cyc = 0;

  seq_arbiter #(.n(4), .aw(5), .tmo(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr     (addr),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .seq_addr (seq_addr),
    .seq_jump (seq_jump),
    .seq_stop (seq_stop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] val, input logic [31:0] adr,
                      input int delay);
    ev_t e;
    e.kind = kind;
    e.val = val;
    e.adr = adr;
    e.delay = delay;
    q.push_back(e);
  endtask

  task automatic handle(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      check("unexpected event kind", 32'(kind), 32'hdead);
      return;
    end
    e = q.pop_front();
    check("event kind", 32'(kind), 32'(e.kind));
    if (kind != e.kind) return;
    case (kind)
      EvJump: begin
        check("grant at jump", 32'(grant), e.val);
        check("seq_addr at jump", 32'(seq_addr), e.adr);
      end
      EvDone: check("done pulse", 32'(done), e.val);
      default: begin
        check("err latency", 32'(cyc - jump_cyc), 32'(e.delay));
        check("grant at err", 32'(grant), 32'd0);
      end
    endcase
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("grant/done/err consistency",
            32'(($countones(grant) <= 1) && !((done != '0) && err)), 32'd1);
      if (seq_jump) begin
        jump_cyc = cyc;
        handle(EvJump);
      end
      if (done != '0) handle(EvDone);
      if (err) handle(EvErr);
    end
  end

  task automatic wait_sig(input int which, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(posedge clk);
      #1;
      case (which)
        0: seen = seq_jump;
        1: seen = (done != '0);
        default: seen = err;
      endcase
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_prog(input int drop, input int len);
    repeat (drop) @(posedge clk);
    #1 seq_stop = 1'b0;
    repeat (len) @(posedge clk);
    #1 seq_stop = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single requester, full run
    addr = {5'd3, 5'd25, 5'd19, 5'd2};
    repeat (2) @(posedge clk);
    #1;
    check("reset grant", 32'(grant), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset seq_jump", 32'(seq_jump), 32'd0);
    check("reset seq_addr", 32'(seq_addr), 32'd0);
    req = 4'b0001;
    push(EvJump, 32'b0001, 32'd2, 0);
    push(EvDone, 32'b0001, 0, 0);
    rst_n = 1'b1;
    wait_sig(0, "t1 jump timeout");
    run_prog(2, 10);
    wait_sig(1, "t1 done timeout");
    req = '0;
    @(posedge clk);
    #1 check("t1 grant cleared", 32'(grant), 32'd0);

    // Round robin with everyone requesting
    addr = {5'd3, 5'd25, 5'd19, 5'd12};
    do_reset();
    push(EvJump, 32'b0001, 32'd12, 0); push(EvDone, 32'b0001, 0, 0);
    push(EvJump, 32'b0010, 32'd19, 0); push(EvDone, 32'b0010, 0, 0);
    push(EvJump, 32'b0100, 32'd25, 0); push(EvDone, 32'b0100, 0, 0);
    push(EvJump, 32'b1000, 32'd3,  0); push(EvDone, 32'b1000, 0, 0);
    push(EvJump, 32'b0001, 32'd12, 0); push(EvDone, 32'b0001, 0, 0);
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_sig(0, "t2 jump timeout");
      run_prog(2, 3);
      wait_sig(1, "t2 done timeout");
    end
    req = '0;

    // Start timeout: err 16 cycles after the jump cycle, then requester 1 served
    repeat (3) @(posedge clk);
    do_reset();
    push(EvJump, 32'b0001, 32'd12, 0);
    push(EvErr, 0, 0, 16);
    push(EvJump, 32'b0010, 32'd19, 0);
    push(EvDone, 32'b0010, 0, 0);
    req = 4'b0011;
    wait_sig(0, "t3 jump timeout");
    wait_sig(2, "t3 err timeout");
    wait_sig(0, "t3 second jump timeout");
    run_prog(2, 4);
    wait_sig(1, "t3 done timeout");
    req = '0;

    // Sequencer busy at reset release
    repeat (3) @(posedge clk);
    seq_stop = 1'b0;
    req = 4'b0010;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("t4 no grant while busy", 32'(grant), 32'd0);
    end
    push(EvJump, 32'b0010, 32'd19, 0);
    push(EvDone, 32'b0010, 0, 0);
    seq_stop = 1'b1;
    wait_sig(0, "t4 jump timeout");
    run_prog(2, 4);
    wait_sig(1, "t4 done timeout");
    req = '0;

    // Reset mid-run abandons without done
    repeat (3) @(posedge clk);
    do_reset();
    push(EvJump, 32'b0001, 32'd12, 0);
    req = 4'b0001;
    wait_sig(0, "t5 jump timeout");
    repeat (2) @(posedge clk);
    #1 seq_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5 async grant", 32'(grant), 32'd0);
    check("t5 async seq_addr", 32'(seq_addr), 32'd0);
    check("t5 async done/err/jump", {29'd0, done != '0, err, seq_jump}, 32'd0);
    seq_stop = 1'b1;
    req = 4'b0011;
    push(EvJump, 32'b0001, 32'd12, 0);
    push(EvDone, 32'b0001, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_sig(0, "t5 jump after reset timeout");
    run_prog(2, 4);
    wait_sig(1, "t5 done timeout");
    req = '0;

    // Owner drops req mid-run
    repeat (3) @(posedge clk);
    do_reset();
    push(EvJump, 32'b0100, 32'd25, 0);
    push(EvDone, 32'b0100, 0, 0);
    req = 4'b0100;
    wait_sig(0, "t6 jump timeout");
    repeat (2) @(posedge clk);
    #1 seq_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1 req = '0;
    repeat (3) @(posedge clk);
    #1 seq_stop = 1'b1;
    wait_sig(1, "t6 done timeout");

    repeat (4) @(posedge clk);
    #1 check("scoreboard drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
